// File: rtl/mem_store_buffer_pkg.sv
// Shared types for the MEM-stage store buffer.
// Store-mask encodings and the queued entry record.
package mem_store_buffer_pkg;

   localparam logic [3:0] MASK_NONE = 4'b0000;
   localparam logic [3:0] MASK_SB   = 4'b0001;
   localparam logic [3:0] MASK_SH   = 4'b0011;
   localparam logic [3:0] MASK_SW   = 4'b1111;

   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  mask;
      logic [31:0] data;
   } sb_entry_t;

   function automatic logic is_store(input logic [3:0] mask);
      return mask != MASK_NONE;
   endfunction

endpackage

// File: rtl/mem_store_buffer_if.sv
// MEM-stage side bundle of the store buffer:
// instruction inputs, cache-port outputs and status.
interface mem_store_buffer_if #(
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          bubbleM;
   logic          flushM;
   logic [3:0]    store_mask;
   logic          load_en;
   logic          reg_write_en;
   logic [31:0]   addr;
   logic [31:0]   store_data;
   logic [31:0]   cache_addr;
   logic [3:0]    cache_write_en;
   logic [31:0]   cache_in_data;
   logic          stall_req;
   logic          empty;
   logic          full;
   logic [CW-1:0] count;

   modport master (
      output bubbleM, flushM, store_mask,
      output load_en, reg_write_en,
      output addr, store_data,
      input  cache_addr, cache_write_en,
      input  cache_in_data, stall_req,
      input  empty, full, count
   );

   modport slave (
      input  bubbleM, flushM, store_mask,
      input  load_en, reg_write_en,
      input  addr, store_data,
      output cache_addr, cache_write_en,
      output cache_in_data, stall_req,
      output empty, full, count
   );

endinterface

// File: rtl/mem_store_buffer_fifo.sv
// Circular store queue: storage, pointers, count and
// per-slot valid bits exposed for the word-address compare.
module store_buffer_fifo
   import mem_store_buffer_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    push,
   input  sb_entry_t               wr,
   input  logic                    pop,
   output sb_entry_t               head,
   output logic [DEPTH-1:0][29:0]  slot_word,
   output logic [DEPTH-1:0]        valid,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    empty,
   output logic                    full
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   sb_entry_t [DEPTH-1:0] mem;
   logic [AW-1:0]         hd;
   logic [AW-1:0]         tl;
   logic [CW-1:0]         cnt;
   logic [DEPTH-1:0]      vld;
   logic [DEPTH-1:0]      vld_n;

   always_comb begin
      vld_n = vld;
      if (pop)  vld_n[hd] = 1'b0;
      if (push) vld_n[tl] = 1'b1;
   end

   // Valid bits clear asynchronously so the compare sees nothing after reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hd  <= '0;
         tl  <= '0;
         cnt <= '0;
         vld <= '0;
      end else begin
         vld <= vld_n;
         if (push) tl <= tl + AW'(1);
         if (pop)  hd <= hd + AW'(1);
         unique case ({push, pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[tl] <= wr;
   end

   always_comb begin
      for (int i = 0; i < DEPTH; i++)
         slot_word[i] = mem[i].addr[31:2];
   end

   assign head  = mem[hd];
   assign valid = vld;
   assign count = cnt;
   assign empty = (cnt == '0);
   assign full  = (cnt == CW'(DEPTH));

endmodule

// File: rtl/mem_store_buffer.sv
// MEM-stage store buffer: queues committed stores and drains
// them in order whenever the cache address port is idle.
module mem_store_buffer
   import mem_store_buffer_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   mem_store_buffer_if.slave sb
);
   localparam int CW = $clog2(DEPTH) + 1;

   sb_entry_t               head;
   sb_entry_t               wr;
   logic [DEPTH-1:0][29:0]  slot_word;
   logic [DEPTH-1:0]        valid;
   logic [CW-1:0]           count;
   logic                    empty;
   logic                    full;

   logic live;
   logic st;
   logic hit_any;
   logic load_hit;
   logic stall;
   logic drain;
   logic enq;

   store_buffer_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (enq),
      .wr        (wr),
      .pop       (drain),
      .head      (head),
      .slot_word (slot_word),
      .valid     (valid),
      .count     (count),
      .empty     (empty),
      .full      (full)
   );

   // Word-granular alias check; byte masks are ignored on purpose
   always_comb begin
      hit_any = 1'b0;
      for (int i = 0; i < DEPTH; i++)
         if (valid[i] && slot_word[i] == sb.addr[31:2])
            hit_any = 1'b1;
   end

   assign live     = !sb.bubbleM && !sb.flushM;
   assign st       = is_store(sb.store_mask);
   assign load_hit = live && sb.load_en && hit_any;
   assign stall    = load_hit || (live && st && full);
   assign enq      = live && st && !stall;

   // The cache port is free unless the MEM op feeds WB
   assign drain = !empty &&
                  (stall || sb.bubbleM || sb.flushM ||
                   (!sb.load_en && !sb.reg_write_en));

   assign wr = '{addr: sb.addr,
                 mask: sb.store_mask,
                 data: sb.store_data};

   assign sb.cache_addr     = drain ? head.addr : sb.addr;
   assign sb.cache_write_en = drain ? head.mask : 4'b0000;
   assign sb.cache_in_data  = drain ? head.data : sb.store_data;
   assign sb.stall_req      = stall;
   assign sb.empty          = empty;
   assign sb.full           = full;
   assign sb.count          = count;

endmodule
